// File: rtl/dm_access_unit.sv
// Memory-stage load/store data path: store packing and byte enables in M, load extraction in W.
// Optional define ALIGN_EXC_EN enables the misaligned-access exceptions.
module dm_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              m_valid,
  input  logic [2:0]        m_op,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic [3:0]        dm_byteen,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              w_load,
  output logic [DATA_W-1:0] w_rdata,
  output logic              exc_adel,
  output logic              exc_ades
);

  localparam logic [2:0] op_lw  = 3'b000;
  localparam logic [2:0] op_lh  = 3'b001;
  localparam logic [2:0] op_lhu = 3'b010;
  localparam logic [2:0] op_lb  = 3'b011;
  localparam logic [2:0] op_lbu = 3'b100;
  localparam logic [2:0] op_sw  = 3'b101;
  localparam logic [2:0] op_sh  = 3'b110;
  localparam logic [2:0] op_sb  = 3'b111;

  logic       is_load;
  logic [3:0] byteen_raw;
  logic [2:0] w_op;
  logic [1:0] w_off;
  logic       w_load_r;
  logic [15:0] half;
  logic [7:0]  bytev;

  assign is_load = (m_op <= op_lbu);

`ifdef ALIGN_EXC_EN
  assign exc_adel = m_valid & (((m_op == op_lw) & (m_addr[1:0] != 2'b00)) |
                               (((m_op == op_lh) | (m_op == op_lhu)) & m_addr[0]));
  assign exc_ades = m_valid & (((m_op == op_sw) & (m_addr[1:0] != 2'b00)) |
                               ((m_op == op_sh) & m_addr[0]));
`else
  // Low address bits that would be misaligned are simply ignored.
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

  assign dm_addr = {m_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    byteen_raw = 4'b0000;
    dm_wdata   = m_wdata;
    case (m_op)
      op_sw: byteen_raw = 4'b1111;
      op_sh: begin
        byteen_raw = m_addr[1] ? 4'b1100 : 4'b0011;
        dm_wdata   = {2{m_wdata[15:0]}};
      end
      op_sb: begin
        byteen_raw = 4'b0001 << m_addr[1:0];
        dm_wdata   = {4{m_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  assign dm_byteen = (m_valid && !reset && !stall && !exc_ades) ? byteen_raw : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_op     <= op_lw;
      w_off    <= 2'b00;
      w_load_r <= 1'b0;
    end else if (!stall) begin
      w_op     <= m_op;
      w_off    <= m_addr[1:0];
      w_load_r <= m_valid & is_load & ~exc_adel;
    end
  end

  assign w_load = w_load_r;

  always_comb begin
    half = w_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (w_off)
      2'd0:    bytev = dm_rdata[7:0];
      2'd1:    bytev = dm_rdata[15:8];
      2'd2:    bytev = dm_rdata[23:16];
      default: bytev = dm_rdata[31:24];
    endcase
    w_rdata = '0;
    if (w_load_r) begin
      case (w_op)
        op_lw:   w_rdata = dm_rdata;
        op_lh:   w_rdata = {{16{half[15]}}, half};
        op_lhu:  w_rdata = {16'h0000, half};
        op_lb:   w_rdata = {{24{bytev[7]}}, bytev};
        op_lbu:  w_rdata = {24'h000000, bytev};
        default: w_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: expected store packs and load results are queued at
// issue time and popped by a monitor whenever the DUT presents a store or a W-stage load.
module tb_dm_access_unit;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011, LBU = 3'b100;
  localparam logic [2:0] SW = 3'b101, SH = 3'b110, SB = 3'b111;

  logic        clk = 1'b0;
  logic        reset, stall, m_valid;
  logic [2:0]  m_op;
  logic [31:0] m_addr, m_wdata, dm_addr, dm_wdata, dm_rdata, w_rdata;
  logic [3:0]  dm_byteen;
  logic        w_load, exc_adel, exc_ades;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] load_q[$];
  logic [67:0] store_q[$];

  dm_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .m_valid(m_valid), .m_op(m_op),
    .m_addr(m_addr), .m_wdata(m_wdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_byteen(dm_byteen), .dm_rdata(dm_rdata), .w_load(w_load), .w_rdata(w_rdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: sample mid-cycle, pop whenever a store commits or a load sits in W.
  always @(negedge clk) begin
    if (w_load) begin
      if (load_q.size() == 0) chk("load_unexpected", {36'h0, w_rdata}, 68'h0);
      else chk("load_data", {36'h0, w_rdata}, {36'h0, load_q.pop_front()});
    end
    if (dm_byteen != 4'b0000) begin
      if (store_q.size() == 0) chk("store_unexpected", {dm_byteen, dm_wdata, dm_addr}, 68'h0);
      else chk("store_pack", {dm_byteen, dm_wdata, dm_addr}, store_q.pop_front());
    end
  end

  task automatic cyc(input logic rst, input logic stl, input logic v, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
    @(posedge clk);
    #1;
    reset = rst; stall = stl; m_valid = v; m_op = op;
    m_addr = addr; m_wdata = wd; dm_rdata = rd;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; m_valid = 1'b0; m_op = LW;
    m_addr = 32'h0; m_wdata = 32'h0; dm_rdata = 32'h0;
    repeat (2) @(posedge clk);

    // Reset with a store in M: no write, W empty afterwards.
    cyc(1, 0, 1, SW, 32'h10, 32'hDEADBEEF, 32'h0);
    @(negedge clk);
    chk("reset_byteen", {64'h0, dm_byteen}, 68'h0);
    cyc(0, 0, 0, LW, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("reset_w_load", {67'h0, w_load}, 68'h0);
    chk("reset_w_rdata", {36'h0, w_rdata}, 68'h0);

    // Store packing.
    cyc(0, 0, 1, SB, 32'h13, 32'h123456AB, 32'h0);
    store_q.push_back({4'b1000, 32'hABABABAB, 32'h10});
    cyc(0, 0, 1, SH, 32'h12, 32'h123456AB, 32'h0);
    store_q.push_back({4'b1100, 32'h56AB56AB, 32'h10});
    cyc(0, 0, 1, SW, 32'h44, 32'h0BADF00D, 32'h0);
    store_q.push_back({4'b1111, 32'h0BADF00D, 32'h44});

    // Byte and half loads, result one cycle later against that cycle's rdata.
    cyc(0, 0, 1, LB, 32'h21, 32'h0, 32'h0);
    load_q.push_back(32'hFFFFFF80);
    cyc(0, 0, 1, LBU, 32'h21, 32'h0, 32'h112280FF);
    load_q.push_back(32'h00000080);
    cyc(0, 0, 1, LH, 32'h22, 32'h0, 32'h112280FF);
    load_q.push_back(32'hFFFF8001);
    cyc(0, 0, 1, LHU, 32'h22, 32'h0, 32'h80011234);
    load_q.push_back(32'h00008001);
    cyc(0, 0, 1, LH, 32'h20, 32'h0, 32'h80011234);
    load_q.push_back(32'h00001234);
    cyc(0, 0, 1, LW, 32'h24, 32'h0, 32'h80011234);
    load_q.push_back(32'hDEADBEEF);
    cyc(0, 0, 1, LB, 32'h23, 32'h0, 32'hDEADBEEF);
    load_q.push_back(32'hFFFFFFA5);

    // Stall with SW in M: no write, W holds LB byte 3 tracking rdata.
    cyc(0, 1, 1, SW, 32'h30, 32'hCAFEF00D, 32'hA5000000);
    @(negedge clk);
    chk("stall1_byteen", {64'h0, dm_byteen}, 68'h0);
    load_q.push_back(32'h0000007F);
    cyc(0, 1, 1, SW, 32'h30, 32'hCAFEF00D, 32'h7F000000);
    @(negedge clk);
    chk("stall2_byteen", {64'h0, dm_byteen}, 68'h0);
    load_q.push_back(32'hFFFFFF81);
    cyc(0, 0, 0, LW, 32'h0, 32'h0, 32'h81000000);
    cyc(0, 0, 0, LW, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("after_stall_w_load", {67'h0, w_load}, 68'h0);

    // Reset while a load is in W drops it on the following cycle.
    cyc(0, 0, 1, LBU, 32'h20, 32'h0, 32'h0);
    load_q.push_back(32'h000000C3);
    cyc(1, 1, 0, LW, 32'h0, 32'h0, 32'h000000C3);
    cyc(0, 0, 0, LW, 32'h0, 32'h0, 32'h000000C3);
    @(negedge clk);
    chk("reset_drop_w_load", {67'h0, w_load}, 68'h0);
    chk("reset_drop_w_rdata", {36'h0, w_rdata}, 68'h0);

    // Misaligned accesses.
    cyc(0, 0, 1, LW, 32'h22, 32'h0, 32'h0);
    @(negedge clk);
`ifdef ALIGN_EXC_EN
    chk("lw_mis_adel", {67'h0, exc_adel}, 68'h1);
    cyc(0, 0, 1, SH, 32'h31, 32'h0000BEEF, 32'h01020304);
    @(negedge clk);
    chk("lw_mis_w_load", {67'h0, w_load}, 68'h0);
    chk("sh_mis_ades", {67'h0, exc_ades}, 68'h1);
    chk("sh_mis_byteen", {64'h0, dm_byteen}, 68'h0);
`else
    chk("lw_mis_adel", {67'h0, exc_adel}, 68'h0);
    load_q.push_back(32'h01020304);
    cyc(0, 0, 1, SH, 32'h31, 32'h0000BEEF, 32'h01020304);
    store_q.push_back({4'b0011, 32'hBEEFBEEF, 32'h30});
    @(negedge clk);
    chk("sh_mis_ades", {67'h0, exc_ades}, 68'h0);
`endif
    cyc(0, 0, 0, LW, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("load_q_drained", {36'h0, 32'(load_q.size())}, 68'h0);
    chk("store_q_drained", {36'h0, 32'(store_q.size())}, 68'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
